tt_um_serial_subtractor: RTL
============================

TT_UM_SERIAL_SUBTRACTOR -- requirements
Module: tt_um_serial_subtractor

Interface
REQ-001: Port list SHALL be:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ui_in  input  8  operand data bus.
- uo_out  output  8  8-bit difference register.
- uio_in  input  8  control:
  - [0] load_a strobe.
  - [1] load_b strobe.
  - [2] start.
  - [7:3] unused.
- uio_out  output  8  status:
  - [3:0] = 0.
  - [4] borrow.
  - [5] busy.
  - [6] done.
  - [7] serial difference bit.
- uio_oe  output  8  constant 8'hF0.
- ena  input  1  unused.
REQ-002: Unused inputs (ena, uio_in[7:3]) SHALL be consumed without affecting behaviour.

Function
REQ-003: Operand registers A and B (8 bits each) SHALL capture ui_in on any edge with load_a or load_b high, respectively, while not in RUN.
- Both strobes high on the same edge loads the same value into A and B.
REQ-004: FSM states SHALL be IDLE, RUN and DONE.
- IDLE/DONE -> RUN on an edge with start=1.
- RUN -> DONE on the 8th RUN edge.
- No other transitions except reset.
REQ-005: On the start edge the block SHALL:
- copy A and B into working shift registers;
- clear the borrow flop and the 3-bit bit counter;
- clear done.
REQ-006: Each RUN edge SHALL process bit i (LSB first):
- d = a_i XOR b_i XOR br.
- br' = (NOT a_i AND b_i) OR (NOT(a_i XOR b_i) AND br).
- d is shifted into the difference shift register from the MSB side.
- The counter increments.
REQ-007: On the RUN edge where the counter equals 7, the block SHALL:
- load the completed difference into the result register driving uo_out;
- load final br' into the borrow output;
- set done=1 and enter DONE.
REQ-008: Latency: done and valid uo_out SHALL appear exactly 8 clock edges after the start edge. busy (uio_out[5]) is 1 exactly while in RUN.
REQ-009: uio_out[7] SHALL show the combinational d of the current bit during RUN and 0 otherwise.
REQ-010: While in RUN, start, load_a and load_b SHALL be ignored.
REQ-011: If load and start are high on the same IDLE/DONE edge, the computation SHALL use the pre-edge operand values, and the operand register SHALL take the new value.
REQ-012: uo_out and borrow SHALL hold their last completed values through RUN. They change only at the RUN->DONE edge.
REQ-013: done SHALL remain 1 in DONE until the next start edge or reset.
REQ-014: Arithmetic SHALL be unsigned modulo 2^8. Borrow=1 exactly when A < B.

Reset
REQ-015: rst_n=0 SHALL asynchronously force the following, regardless of current state (including mid-RUN):
- state = IDLE;
- A, B, working registers, counter and borrow flop = 0;
- uo_out = 8'h00;
- uio_out = 8'h00.
REQ-016: After rst_n deasserts, the first start SHALL be honoured on the first rising edge where it is high.

Configuration
REQ-017: Macro SUB_SATURATE_EN controls result saturation at the RUN->DONE edge:
- Defined: if final borrow=1, the result register SHALL load 8'h00 instead of the wrapped difference. The borrow output still reports 1.
- Undefined: the result register SHALL load the modulo-2^8 difference.

Verification
REQ-018: Load A=200 (0xC8), B=58 (0x3A), start -> after 8 edges: uo_out=0x8E, borrow=0, done=1; busy high for exactly 8 cycles.
REQ-019: Load A=5, B=9, start -> uo_out=0xFC and borrow=1 without SUB_SATURATE_EN; uo_out=0x00 and borrow=1 with it.
REQ-020: Load A=0xFF, B=0xFF, start -> uo_out=0x00, borrow=0; uio_out[7] sequence is 0 for all 8 RUN cycles.
REQ-021: Start 0x10-0x01 (expected result 0x0F); on RUN cycle 3 pulse start and load_a with ui_in=0x99 -> both ignored; result 0x0F, done at edge 8, A still 0x10.
REQ-022: Start 0x80-0x01, assert rst_n=0 on RUN cycle 4 -> immediately busy=0, done=0, uo_out=0x00; after release, a new start with A=B=0 yields 0x00, borrow=0.

Source files
------------

// File: rtl/tt_um_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tt_um_serial_subtractor
//
// Bit-serial 8-bit unsigned subtractor (A - B), LSB first, one bit per clock.
// Operands are loaded through ui_in with the load_a/load_b strobes. A start
// strobe launches an 8-cycle run. The result and the final borrow update
// together when the run completes, and they hold their values until then.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ui_in    : operand data bus
//   uo_out   : result register (A - B mod 256)
//   uio_in   : [0] load_a, [1] load_b, [2] start, [7:3] unused
//   uio_out  : [3:0] 0, [4] borrow, [5] busy, [6] done, [7] serial difference bit
//   uio_oe   : constant 8'hF0
//   ena      : unused
//
// Build option
//   SUB_SATURATE_EN : when defined, a borrowing result loads 8'h00 instead of
//                     the wrapped difference. The borrow output still reads 1.
// ---------------------------------------------------------------------------
module tt_um_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] wa_q, wa_d;      // working copy of A, shifted right each run cycle
  logic [7:0] wb_q, wb_d;      // working copy of B
  logic [7:0] diff_q, diff_d;  // difference bits enter from the MSB side
  logic [7:0] res_q, res_d;
  logic [2:0] cnt_q, cnt_d;
  logic       br_q, br_d;
  logic       borrow_q, borrow_d;
  logic       done_q, done_d;

  logic       load_a, load_b, start;
  logic       bit_a, bit_b, bit_d, br_nx;
  logic [7:0] diff_nx;
  logic       unused_inputs;

  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];

  assign unused_inputs = ^{ena, uio_in[7:3]};

  // Full-subtractor slice for the current bit
  assign bit_a   = wa_q[0];
  assign bit_b   = wb_q[0];
  assign bit_d   = bit_a ^ bit_b ^ br_q;
  assign br_nx   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  assign diff_nx = {bit_d, diff_q[7:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    diff_d   = diff_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    done_d   = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (load_a) a_d = ui_in;
        if (load_b) b_d = ui_in;
        if (start) begin
          // Working copies take the pre-edge operands, even when a load
          // strobe arrives on the same edge.
          state_d = StRun;
          wa_d    = a_q;
          wb_d    = b_q;
          br_d    = 1'b0;
          cnt_d   = 3'd0;
          done_d  = 1'b0;
        end
      end
      StRun: begin
        wa_d   = {1'b0, wa_q[7:1]};
        wb_d   = {1'b0, wb_q[7:1]};
        br_d   = br_nx;
        diff_d = diff_nx;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d  = StDone;
          borrow_d = br_nx;
          done_d   = 1'b1;
`ifdef SUB_SATURATE_EN
          res_d    = br_nx ? 8'h00 : diff_nx;
`else
          res_d    = diff_nx;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      wa_q     <= 8'h00;
      wb_q     <= 8'h00;
      diff_q   <= 8'h00;
      res_q    <= 8'h00;
      cnt_q    <= 3'd0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      diff_q   <= diff_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  logic busy;
  assign busy = (state_q == StRun);

  assign uo_out  = res_q;
  assign uio_out = {busy & bit_d, done_q, busy, borrow_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
